// File: rtl/vcg_pkg.sv
// Shared constants and helpers for the vcg modulo counter family.
// Helpers operate on MAX_W-bit values; callers zero-extend and slice.
package vcg_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Loads at or above the modulus saturate to the last legal count.
  function automatic logic [MAX_W-1:0] clamp(input logic [MAX_W-1:0] d,
                                             input longint unsigned m);
    logic [63:0] m_last;
    m_last = m - 64'd1;
    return (64'(d) >= m) ? m_last[MAX_W-1:0] : d;
  endfunction

endpackage

// File: rtl/vcg_prescaler.sv
// Clock-enable prescaler: emits one tick per DIV enabled cycles.
// DIV=1 degenerates to a passthrough with no state.
module vcg_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic r,
  input  logic clr,
  input  logic ce,
  output logic tick,
  output logic last
);

  if (DIV == 1) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ r ^ clr;
    assign last = 1'b1;
    assign tick = ce;
  end else begin : g_div
    localparam int unsigned     PW    = $clog2(DIV);
    localparam logic [PW-1:0]   P_MAX = PW'(DIV - 1);

    logic [PW-1:0] p_q, p_d;

    // A load restarts the prescale phase so the next count is a full DIV away.
    always_comb begin
      p_d = p_q;
      if (clr) begin
        p_d = '0;
      end else if (ce) begin
        p_d = (p_q >= P_MAX) ? '0 : p_q + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (r) p_q <= '0;
      else   p_q <= p_d;
    end

    assign last = (p_q == P_MAX);
    assign tick = ce & last;
  end

endmodule

// File: rtl/vcg_mod_counter.sv
// Cascadable modulo-MOD up/down counter with ce prescaler and synchronous load.
// Define VCG_GRAY_OUT_EN to add the registered Gray-coded output Yg.
module vcg_mod_counter
  import vcg_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10,
  parameter int unsigned DIV   = 2
) (
  input  logic             clk,
  input  logic             r,
  input  logic             ce,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Y,
  output logic             TC,
  output logic             CEO
`ifdef VCG_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] Yg
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_W || MOD < 2 || 64'(MOD) > (64'd1 << WIDTH) || DIV < 1)
  begin : g_bad_param
    $error("vcg_mod_counter: illegal WIDTH/MOD/DIV combination");
  end

  localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(MOD - 1);

  logic             tick, last;
  logic [WIDTH-1:0] y_q, y_d;
  logic [MAX_W-1:0] ld_ext;
  logic             unused_ld;

  vcg_prescaler #(.DIV(DIV)) u_presc (
    .clk  (clk),
    .r    (r),
    .clr  (ld),
    .ce   (ce),
    .tick (tick),
    .last (last)
  );

  assign ld_ext    = clamp(MAX_W'(din), 64'(MOD));
  assign unused_ld = ^ld_ext;

  // Out-of-range values are treated as the wrap point in either direction.
  always_comb begin
    y_d = y_q;
    if (ld) begin
      y_d = ld_ext[WIDTH-1:0];
    end else if (tick) begin
      if (dir == DIR_UP) y_d = (y_q >= Y_MAX) ? '0 : y_q + WIDTH'(1);
      else               y_d = (y_q == '0 || y_q > Y_MAX) ? Y_MAX : y_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (r) y_q <= '0;
    else   y_q <= y_d;
  end

  assign Y   = y_q;
  assign TC  = last & ((dir == DIR_UP) ? (y_q == Y_MAX) : (y_q == '0));
  assign CEO = ce & TC;

`ifdef VCG_GRAY_OUT_EN
  logic [WIDTH-1:0] yg_q;
  logic [MAX_W-1:0] gray_full;
  logic             unused_gray;

  assign gray_full   = bin2gray(MAX_W'(y_d));
  assign unused_gray = ^gray_full;

  always_ff @(posedge clk) begin
    if (r) yg_q <= '0;
    else   yg_q <= gray_full[WIDTH-1:0];
  end

  assign Yg = yg_q;
`endif

endmodule

// File: tb/tb_vcg_mod_counter.sv
// Directed bench for vcg_mod_counter: single stage, load/reset priority,
// a two-digit chained decade counter and a MOD16 Gray stage.
module tb_vcg_mod_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  logic [31:0] exp_q[$];

  // main DUT: WIDTH4 MOD10 DIV2
  logic       r, ce, dir, ld;
  logic [3:0] din, y;
  logic       tc, ceo;

  // chained decade pair: MOD10 DIV1
  logic       c_r, c_ce, c_dir, c_ld;
  logic [3:0] c_din, lo_y, hi_y;
  logic       lo_tc, lo_ceo, hi_tc, hi_ceo;

  // Gray stage: MOD16 DIV1
  logic       g_r, g_ce, g_dir, g_ld;
  logic [3:0] g_din, g_y;
  logic       g_tc, g_ceo;

`ifdef VCG_GRAY_OUT_EN
  logic [3:0] yg, lo_yg, hi_yg, g_yg;
`endif

  vcg_mod_counter #(.WIDTH(4), .MOD(10), .DIV(2)) u_dut (
    .clk(clk), .r(r), .ce(ce), .dir(dir), .ld(ld), .din(din),
    .Y(y), .TC(tc), .CEO(ceo)
`ifdef VCG_GRAY_OUT_EN
    , .Yg(yg)
`endif
  );

  vcg_mod_counter #(.WIDTH(4), .MOD(10), .DIV(1)) u_lo (
    .clk(clk), .r(c_r), .ce(c_ce), .dir(c_dir), .ld(c_ld), .din(c_din),
    .Y(lo_y), .TC(lo_tc), .CEO(lo_ceo)
`ifdef VCG_GRAY_OUT_EN
    , .Yg(lo_yg)
`endif
  );

  vcg_mod_counter #(.WIDTH(4), .MOD(10), .DIV(1)) u_hi (
    .clk(clk), .r(c_r), .ce(lo_ceo), .dir(c_dir), .ld(c_ld), .din(c_din),
    .Y(hi_y), .TC(hi_tc), .CEO(hi_ceo)
`ifdef VCG_GRAY_OUT_EN
    , .Yg(hi_yg)
`endif
  );

  vcg_mod_counter #(.WIDTH(4), .MOD(16), .DIV(1)) u_gray (
    .clk(clk), .r(g_r), .ce(g_ce), .dir(g_dir), .ld(g_ld), .din(g_din),
    .Y(g_y), .TC(g_tc), .CEO(g_ceo)
`ifdef VCG_GRAY_OUT_EN
    , .Yg(g_yg)
`endif
  );

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned pulses;
    logic [31:0] e;
    logic [3:0]  gexp;
`ifdef VCG_GRAY_OUT_EN
    logic [3:0]  yg_prev;
`endif

    r = 1'b1; ce = 1'b0; dir = 1'b1; ld = 1'b0; din = '0;
    c_r = 1'b1; c_ce = 1'b0; c_dir = 1'b1; c_ld = 1'b0; c_din = '0;
    g_r = 1'b1; g_ce = 1'b0; g_dir = 1'b1; g_ld = 1'b0; g_din = '0;

    // 1: count up, DIV2
    step(); step();
    r = 1'b0;
    check_eq("t1_rst_y", 32'(y), 0);
    check_eq("t1_rst_tc", 32'(tc), 0);
    check_eq("t1_rst_ceo", 32'(ceo), 0);
    ce = 1'b1;
    for (int n = 1; n <= 20; n++) exp_q.push_back(32'((n / 2) % 10));
    for (int n = 1; n <= 20; n++) begin
      step();
      e = exp_q.pop_front();
      check_eq($sformatf("t1_y_n%0d", n), 32'(y), e);
      check_eq($sformatf("t1_ceo_n%0d", n), 32'(ceo), (n == 19) ? 1 : 0);
    end

    // 2: count down
    ce = 1'b0; r = 1'b1;
    step();
    r = 1'b0; dir = 1'b0;
    check_eq("t2_rst_tc", 32'(tc), 0);
    ce = 1'b1;
    pulses = 0;
    for (int n = 1; n <= 22; n++) begin
      step();
      check_eq($sformatf("t2_y_n%0d", n), 32'(y), 32'((10 - (n / 2) % 10) % 10));
      if (n == 1) check_eq("t2_tc_at0", 32'(tc), 1);
      if (ceo) pulses++;
    end
    check_eq("t2_ceo_pulses", pulses, 2);

    // 3: load, clamp, load without ce, prescaler cleared by load
    dir = 1'b1; ce = 1'b1; ld = 1'b1; din = 4'd7;
    step();
    check_eq("t3_ld7", 32'(y), 7);
    din = 4'd12;
    step();
    check_eq("t3_ld12_clamp", 32'(y), 9);
    ld = 1'b0;
    check_eq("t3_p_cleared_tc", 32'(tc), 0);
    ce = 1'b0; ld = 1'b1; din = 4'd3;
    step();
    check_eq("t3_ld_no_ce", 32'(y), 3);
    ld = 1'b0; ce = 1'b1;
    step();
    check_eq("t3_hold_p1", 32'(y), 3);
    step();
    check_eq("t3_count4", 32'(y), 4);

    // 4: reset beats load; TC with ce low; dir flip
    r = 1'b1; ld = 1'b1; din = 4'd5;
    step();
    check_eq("t4_r_over_ld", 32'(y), 0);
    r = 1'b0; ce = 1'b0; din = 4'd9;
    step();
    ld = 1'b0; ce = 1'b1;
    step();
    check_eq("t4_y9", 32'(y), 9);
    ce = 1'b0;
    #1;
    check_eq("t4_tc_ce0", 32'(tc), 1);
    check_eq("t4_ceo_ce0", 32'(ceo), 0);
    step();
    check_eq("t4_hold_y", 32'(y), 9);
    check_eq("t4_hold_tc", 32'(tc), 1);
    dir = 1'b0;
    #1;
    check_eq("t4_dir_flip_tc", 32'(tc), 0);
    dir = 1'b1; ce = 1'b1;
    #1;
    check_eq("t4_ceo_ce1", 32'(ceo), 1);
    step();
    check_eq("t4_wrap", 32'(y), 0);

    // 5: chained decade pair 00..99
    c_r = 1'b0; c_ce = 1'b1;
    check_eq("t5_rst_lo", 32'(lo_y), 0);
    check_eq("t5_rst_hi", 32'(hi_y), 0);
    pulses = 0;
    for (int n = 1; n <= 100; n++) begin
      if (hi_ceo) pulses++;
      step();
      check_eq($sformatf("t5_val_n%0d", n), 32'(hi_y) * 10 + 32'(lo_y), 32'(n % 100));
    end
    check_eq("t5_hi_ceo_pulses", pulses, 1);

    // 6: MOD16 stage, Gray output when present
    g_r = 1'b0; g_ce = 1'b1;
    check_eq("t6_rst_y", 32'(g_y), 0);
`ifdef VCG_GRAY_OUT_EN
    check_eq("t6_rst_yg", 32'(g_yg), 0);
    yg_prev = 4'd0;
`endif
    for (int n = 1; n <= 20; n++) begin
      step();
      gexp = 4'(n % 16);
      check_eq($sformatf("t6_y_n%0d", n), 32'(g_y), 32'(gexp));
`ifdef VCG_GRAY_OUT_EN
      check_eq($sformatf("t6_yg_n%0d", n), 32'(g_yg), 32'(gexp ^ (gexp >> 1)));
      check_eq($sformatf("t6_onebit_n%0d", n), 32'($countones(g_yg ^ yg_prev)), 1);
      yg_prev = g_yg;
`endif
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
